// File: rtl/fill_drain_sched_pkg.sv
// fill_drain_sched_pkg: FSM states, fill-entry layout and default sizing for the fill/read scheduler
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
package fill_drain_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WR, S_RD} state_e;
  localparam int DEF_ADDR_WIDTH = `AXI_ADDR_WIDTH;
  localparam int DEF_DATA_WIDTH = `AXI_DATA_WIDTH;
  localparam int DEF_MAX_OUTSTANDING = 4;
  localparam int DEF_STARVE_LIMIT = 8;
  localparam int FILL_DATA_LSB = 0;
  function automatic int fill_addr_lsb(input int data_width);
    return data_width;
  endfunction
endpackage

// File: rtl/fill_credit_cnt.sv
// fill_credit_cnt: outstanding fill-write credit counter
//   inc_i   write accepted by memory      dec_i  write acknowledged
//   count_o writes in flight              full_o no credit left
//   err_o   sticky: ack seen with nothing in flight
module fill_credit_cnt #(
  parameter int MAX = 4,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         full_o,
  output logic         err_o
);
  logic [W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  // a simultaneous accept and ack cancel out, so an ack is only an underflow when it arrives alone
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc_i && !dec_i) cnt_d = cnt_q + 1'b1;
    if (dec_i && !inc_i) begin
      cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      err_d = err_q || (cnt_q == '0);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign count_o = cnt_q;
  assign full_o = cnt_q >= W'(MAX);
  assign err_o = err_q;
endmodule

// File: rtl/fill_drain_sched.sv
// fill_drain_sched: shares one memory command port between fill-FIFO writes and read lookups
//   fill_fifo_*  pop side of the fill FIFO (rden pulse, entry {addr, data} valid next cycle)
//   rd_*         read lookup request/accept, address captured on accept
//   mem_*        command port (valid/ready), write acks on mem_wack_i
//   err_o        sticky write-ack underflow
// Optional FILL_SCHED_AGING_EN: bounds consecutive read grants while a fill waits.
module fill_drain_sched
  import fill_drain_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fill_fifo_empty_i,
  input  logic                             fill_fifo_afull_i,
  output logic                             fill_fifo_rden_o,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fill_fifo_rdata_i,
  input  logic                             rd_valid_i,
  output logic                             rd_ready_o,
  input  logic [ADDR_WIDTH-1:0]            rd_addr_i,
  output logic                             mem_valid_o,
  input  logic                             mem_ready_i,
  output logic                             mem_we_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  input  logic                             mem_wack_i,
  output logic                             err_o
);
  localparam int ADDR_LSB = fill_addr_lsb(DATA_WIDTH);
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [$clog2(MAX_OUTSTANDING+1)-1:0] credit_cnt;
  logic credit_full, wr_accept, fill_ok, fill_urgent, aging_expired;
  assign wr_accept = (state_q == S_WR) && mem_ready_i;
  assign fill_ok = !fill_fifo_empty_i && !credit_full;
  assign fill_urgent = fill_ok && (fill_fifo_afull_i || aging_expired);
  fill_credit_cnt #(.MAX(MAX_OUTSTANDING)) u_credit (
    .clk(clk),
    .rst_n(rst_n),
    .inc_i(wr_accept),
    .dec_i(mem_wack_i),
    .count_o(credit_cnt),
    .full_o(credit_full),
    .err_o(err_o)
  );
`ifdef FILL_SCHED_AGING_EN
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  logic [AGE_W-1:0] age_q, age_d;
  assign aging_expired = age_q == AGE_W'(STARVE_LIMIT);
  // counts reads granted over a grantable fill; saturates so the fill stays urgent until it issues
  always_comb begin
    age_d = age_q;
    if (state_q == S_IDLE && !fill_urgent && rd_valid_i && fill_ok && !aging_expired)
      age_d = age_q + 1'b1;
    if (wr_accept || (state_q == S_IDLE && fill_fifo_empty_i)) age_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) age_q <= '0;
    else age_q <= age_d;
`else
  assign aging_expired = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    fill_fifo_rden_o = 1'b0;
    rd_ready_o = 1'b0;
    case (state_q)
      S_IDLE:
        if (fill_urgent) begin
          fill_fifo_rden_o = 1'b1;
          state_d = S_FETCH;
        end else if (rd_valid_i) begin
          rd_ready_o = 1'b1;
          addr_d = rd_addr_i;
          wdata_d = '0;
          state_d = S_RD;
        end else if (fill_ok) begin
          fill_fifo_rden_o = 1'b1;
          state_d = S_FETCH;
        end
      S_FETCH: begin
        addr_d = fill_fifo_rdata_i[ADDR_LSB +: ADDR_WIDTH];
        wdata_d = fill_fifo_rdata_i[FILL_DATA_LSB +: DATA_WIDTH];
        state_d = S_WR;
      end
      S_WR, S_RD: state_d = mem_ready_i ? S_IDLE : state_q;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  assign mem_valid_o = (state_q == S_WR) || (state_q == S_RD);
  assign mem_we_o = state_q == S_WR;
  assign mem_addr_o = addr_q;
  assign mem_wdata_o = wdata_q;
endmodule

// File: tb/tb_fill_drain_sched.sv
// tb_fill_drain_sched: directed vector table plus corner-case sequences for fill_drain_sched
module tb_fill_drain_sched;
  import fill_drain_sched_pkg::*;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MO = 2;
  localparam int SL = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic empty = 1'b1, afull = 1'b0, rdv = 1'b0, ready = 1'b0, wack = 1'b0;
  logic [AW-1:0] raddr = '0;
  logic [AW+DW-1:0] rdata = '0;
  logic rden, rd_ready, mem_valid, mem_we, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  fill_drain_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .STARVE_LIMIT(SL)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fill_fifo_empty_i(empty),
    .fill_fifo_afull_i(afull),
    .fill_fifo_rden_o(rden),
    .fill_fifo_rdata_i(rdata),
    .rd_valid_i(rdv),
    .rd_ready_o(rd_ready),
    .rd_addr_i(raddr),
    .mem_valid_o(mem_valid),
    .mem_ready_i(ready),
    .mem_we_o(mem_we),
    .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_wack_i(wack),
    .err_o(err)
  );
  typedef struct {
    logic empty, afull, rdv, ready, wack;
    logic [AW-1:0] raddr;
    logic [AW+DW-1:0] rdata;
    logic [4:0] eflags;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewdata;
  } vec_t;
  vec_t tbl[14];
  function automatic vec_t mk(input logic [4:0] in, input logic [AW-1:0] ra, input logic [AW+DW-1:0] rd,
                              input logic [4:0] fl, input logic [AW-1:0] ea, input logic [DW-1:0] ew);
    vec_t v;
    {v.empty, v.afull, v.rdv, v.ready, v.wack} = in;
    v.raddr = ra;
    v.rdata = rd;
    v.eflags = fl;
    v.eaddr = ea;
    v.ewdata = ew;
    return v;
  endfunction
  function automatic logic [63:0] outs();
    return 64'({rden, rd_ready, mem_valid, mem_we, err, mem_addr, mem_wdata});
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    {empty, afull, rdv, ready, wack} = 5'b10000;
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_outs", outs(), 64'd0);
    step();
    rst_n = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int reads;
    bit got;
    // fields: {empty, afull, rd_valid, mem_ready, wack}, rd_addr, fifo entry | {rden, rd_ready, valid, we, err}, addr, wdata
    tbl[0]  = mk(5'b00010, 16'h0000, {16'h0040, 16'hA5A5}, 5'b10000, 16'h0000, 16'h0000);
    tbl[1]  = mk(5'b10010, 16'h0000, {16'h0040, 16'hA5A5}, 5'b00000, 16'h0000, 16'h0000);
    tbl[2]  = mk(5'b10010, 16'h0000, {16'h0000, 16'h0000}, 5'b00110, 16'h0040, 16'hA5A5);
    tbl[3]  = mk(5'b10110, 16'h1234, {16'h0000, 16'h0000}, 5'b01000, 16'h0040, 16'hA5A5);
    tbl[4]  = mk(5'b10100, 16'h1234, {16'h0000, 16'h0000}, 5'b00100, 16'h1234, 16'h0000);
    tbl[5]  = mk(5'b10010, 16'h0000, {16'h0000, 16'h0000}, 5'b00100, 16'h1234, 16'h0000);
    tbl[6]  = mk(5'b01011, 16'h0000, {16'h0080, 16'h5A5A}, 5'b10000, 16'h1234, 16'h0000);
    tbl[7]  = mk(5'b10010, 16'h0000, {16'h0080, 16'h5A5A}, 5'b00000, 16'h1234, 16'h0000);
    tbl[8]  = mk(5'b10010, 16'h0000, {16'h0000, 16'h0000}, 5'b00110, 16'h0080, 16'h5A5A);
    tbl[9]  = mk(5'b01110, 16'h2222, {16'h0000, 16'h0000}, 5'b10000, 16'h0080, 16'h5A5A);
    tbl[10] = mk(5'b10110, 16'h2222, {16'h00C0, 16'h1111}, 5'b00000, 16'h0080, 16'h5A5A);
    tbl[11] = mk(5'b10110, 16'h2222, {16'h0000, 16'h0000}, 5'b00110, 16'h00C0, 16'h1111);
    tbl[12] = mk(5'b01110, 16'h3333, {16'h0000, 16'h0000}, 5'b01000, 16'h00C0, 16'h1111);
    tbl[13] = mk(5'b10010, 16'h0000, {16'h0000, 16'h0000}, 5'b00100, 16'h3333, 16'h0000);
    @(negedge clk);
    chk("reset_outs", outs(), 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      {empty, afull, rdv, ready, wack} = {tbl[i].empty, tbl[i].afull, tbl[i].rdv, tbl[i].ready, tbl[i].wack};
      raddr = tbl[i].raddr;
      rdata = tbl[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(), 64'({tbl[i].eflags, tbl[i].eaddr, tbl[i].ewdata}));
      step();
    end
    // credits exhausted (2 in flight): the pending fill waits for an ack
    {empty, afull, rdv, ready, wack} = 5'b00010;
    rdata = {16'h0100, 16'h2222};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("credit_hold", 64'(rden), 64'd0);
      step();
    end
    wack = 1'b1;
    @(negedge clk);
    chk("credit_hold_ack_cycle", 64'(rden), 64'd0);
    step();
    wack = 1'b0;
    @(negedge clk);
    chk("credit_release", 64'(rden), 64'd1);
    step();
    empty = 1'b1;
    step();
    wack = 1'b1;
    @(negedge clk);
    chk("third_fill_wr", 64'({mem_valid, mem_we, mem_addr}), 64'({2'b11, 16'h0100}));
    step();
    wack = 1'b0;
    @(negedge clk);
    chk("same_cycle_inc_dec", 64'(dut.credit_cnt), 64'd1);
    chk("no_err_yet", 64'(err), 64'd0);
    step();
    // ack with nothing in flight
    do_reset();
    wack = 1'b1;
    step();
    wack = 1'b0;
    @(negedge clk);
    chk("wack_at_zero_err", 64'({err, 2'(dut.credit_cnt)}), 64'({1'b1, 2'd0}));
    step();
    repeat (3) step();
    @(negedge clk);
    chk("err_sticky", 64'(err), 64'd1);
    step();
    do_reset();
    @(negedge clk);
    chk("err_cleared", 64'(err), 64'd0);
    step();
    // backpressure in S_WR holds the command and blocks reads
    {empty, afull, rdv, ready, wack} = 5'b00000;
    rdata = {16'h0ABC, 16'hBEEF};
    step();
    empty = 1'b1;
    step();
    rdv = 1'b1;
    raddr = 16'h0555;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d", k), 64'({mem_valid, mem_we, rd_ready, mem_addr, mem_wdata}),
          64'({3'b110, 16'h0ABC, 16'hBEEF}));
      step();
    end
    ready = 1'b1;
    step();
    @(negedge clk);
    chk("read_after_stall", 64'({rd_ready, mem_valid}), 64'({1'b1, 1'b0}));
    step();
    // reset while a write is stalled, with one write already in flight
    do_reset();
    {empty, afull, rdv, ready, wack} = 5'b00010;
    rdata = {16'h0200, 16'h3333};
    repeat (3) step();
    ready = 1'b0;
    rdata = {16'h0300, 16'h4444};
    repeat (3) step();
    empty = 1'b1;
    @(negedge clk);
    chk("pre_reset_wr", 64'({mem_valid, mem_we, mem_addr, 2'(dut.credit_cnt)}), 64'({2'b11, 16'h0300, 2'd1}));
    rst_n = 1'b0;
    #1;
    chk("reset_mid_wr", outs(), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_state", 64'({2'(dut.state_q), 2'(dut.credit_cnt)}), 64'({2'(S_IDLE), 2'd0}));
`ifdef FILL_SCHED_AGING_EN
    chk("post_reset_age", 64'(dut.age_q), 64'd0);
`endif
    step();
    // reads against a waiting, non-urgent fill
    {empty, afull, rdv, ready, wack} = 5'b00110;
    raddr = 16'h0777;
    rdata = {16'h0400, 16'h5555};
    reads = 0;
    got = 1'b0;
`ifdef FILL_SCHED_AGING_EN
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rden) begin
        got = 1'b1;
        chk("aging_no_dual_grant", 64'(rd_ready), 64'd0);
        break;
      end
      if (rd_ready) reads++;
      step();
    end
    chk("aging_fill_issued", 64'(got), 64'd1);
    chk("aging_reads_before_fill", 64'(reads), 64'(SL));
    step();
`else
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rden) got = 1'b1;
      if (rd_ready) reads++;
      step();
    end
    chk("strict_read_no_fill", 64'(got), 64'd0);
    chk("strict_read_count", 64'(reads), 64'd6);
    afull = 1'b1;
    @(negedge clk);
    chk("afull_fill_wins", 64'({rden, rd_ready}), 64'({1'b1, 1'b0}));
    step();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
